// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Oversampling front end of the UART receiver. Tracks the oversampling edge
//   within each bit and the bit index within the frame, takes three samples
//   around the bit centre and emits the majority vote once per bit period.
//
// Ports
//   CLK              oversampling clock
//   RST              asynchronous reset, active low
//   RX_IN            serial line, already synchronised to CLK
//   Prescale         oversampling ratio (8, 16 or 32; anything else runs as 8)
//   sampler_en       run enable from the RX control FSM
//   sampled_bit      majority-voted value of the current bit (idles at 1)
//   Sample_Available one-cycle strobe marking sampled_bit as new
//   edge_cnt         oversampling edge index within the current bit
//   bit_cnt          bit index within the frame
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sampler_en,
  output logic                  sampled_bit,
  output logic                  Sample_Available,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  localparam logic [PRESCALE_W-1:0] P_8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] P_16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] P_32 = PRESCALE_W'(32);
  localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);

  logic                  en_q;
  logic [PRESCALE_W-1:0] p_q;
  logic                  s0;
  logic                  s1;

  logic                  en_rise;
  logic [PRESCALE_W-1:0] p_sel;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_lo;
  logic [PRESCALE_W-1:0] mid_hi;
  logic [PRESCALE_W-1:0] p_last;
  logic                  vote;

  // en_q resets low, so an enable already high when reset releases is seen
  // as a fresh start and re-latches the ratio.
  assign en_rise = sampler_en & ~en_q;

  always_comb begin
    p_sel = P_8;
    if ((Prescale == P_8) || (Prescale == P_16) || (Prescale == P_32)) begin
      p_sel = Prescale;
    end
  end

  assign mid    = p_q >> 1;
  assign mid_lo = mid - ONE;
  assign mid_hi = mid + ONE;
  assign p_last = p_q - ONE;
  assign vote   = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_q             <= 1'b0;
      p_q              <= P_8;
      edge_cnt         <= '0;
      bit_cnt          <= '0;
      s0               <= 1'b0;
      s1               <= 1'b0;
      sampled_bit      <= 1'b1;
      Sample_Available <= 1'b0;
    end else begin
      en_q             <= sampler_en;
      Sample_Available <= 1'b0;
      if (!sampler_en) begin
        // Disable has priority over a coinciding sample point; the last
        // voted bit is kept for the downstream checkers.
        edge_cnt <= '0;
        bit_cnt  <= '0;
        s0       <= 1'b0;
        s1       <= 1'b0;
      end else if (en_rise) begin
        // The latch cycle counts as edge 0, so the counter holds here.
        p_q      <= p_sel;
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (edge_cnt == p_last) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
        end else begin
          edge_cnt <= edge_cnt + ONE;
        end
        if (edge_cnt == mid_lo) begin
          s0 <= RX_IN;
        end
        if (edge_cnt == mid) begin
          s1 <= RX_IN;
        end
        if (edge_cnt == mid_hi) begin
          sampled_bit      <= vote;
          Sample_Available <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       sampler_en;
  logic       sampled_bit;
  logic       Sample_Available;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  int errors = 0;
  int checks = 0;

  uart_rx_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .RX_IN            (RX_IN),
    .Prescale         (Prescale),
    .sampler_en       (sampler_en),
    .sampled_bit      (sampled_bit),
    .Sample_Available (Sample_Available),
    .edge_cnt         (edge_cnt),
    .bit_cnt          (bit_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One disabled clock, then enable with the given ratio on the next cycle.
  task automatic enable_run(input logic [5:0] pre);
    sampler_en = 1'b0;
    tick();
    Prescale   = pre;
    sampler_en = 1'b1;
  endtask

  // Ticks n_first..n_last clocks since enable. After tick n the bench expects
  // edge (n-1)%p of bit (n-1)/p; the strobe shows while edge = p/2+2.
  // RX_IN during edge e is base ^ mask[e].
  task automatic run_bits(input int p, input int n_first, input int n_last,
                          input logic base, input logic [31:0] mask,
                          input logic exp_bit, input string tag);
    int e;
    int b;
    logic strobe;
    for (int n = n_first; n <= n_last; n++) begin
      tick();
      e = (n - 1) % p;
      b = (n - 1) / p;
      RX_IN = base ^ mask[e];
      strobe = (e == p / 2 + 2);
      check({tag, ".edge"}, 32'(edge_cnt), 32'(e));
      check({tag, ".bit"}, 32'(bit_cnt), 32'(b % 16));
      check({tag, ".strobe"}, 32'(Sample_Available), 32'(strobe));
      if (strobe) check({tag, ".sbit"}, 32'(sampled_bit), 32'(exp_bit));
    end
  endtask

  initial begin
    RST        = 1'b0;
    RX_IN      = 1'b1;
    Prescale   = 6'd8;
    sampler_en = 1'b0;
    #12;
    check("rst.sbit",   32'(sampled_bit), 32'd1);
    check("rst.strobe", 32'(Sample_Available), 32'd0);
    check("rst.edge",   32'(edge_cnt), 32'd0);
    check("rst.bit",    32'(bit_cnt), 32'd0);
    RST = 1'b1;
    tick();

    // P=8, line held low for 10 bits: strobes at n = 7, 15, ..., 79.
    RX_IN = 1'b0;
    enable_run(6'd8);
    run_bits(8, 1, 79, 1'b0, 32'h0, 1'b0, "p8_low");
    check("p8_low.bit9", 32'(bit_cnt), 32'd9);

    // P=16 glitches around edges 7/8/9.
    enable_run(6'd16);
    run_bits(16, 1, 11, 1'b1, 32'h0000_0100, 1'b1, "p16_g8");
    enable_run(6'd16);
    run_bits(16, 1, 11, 1'b1, 32'h0000_0180, 1'b0, "p16_g78");
    enable_run(6'd16);
    run_bits(16, 1, 11, 1'b1, 32'h0000_0280, 1'b0, "p16_g79");

    // P=32, then an illegal 13 that must run as 8.
    enable_run(6'd32);
    run_bits(32, 1, 83, 1'b1, 32'h0, 1'b1, "p32");
    enable_run(6'd13);
    run_bits(8, 1, 23, 1'b0, 32'h0, 1'b0, "p13");

    // Ratio changed mid-run has no effect until the next enable.
    enable_run(6'd8);
    run_bits(8, 1, 15, 1'b1, 32'h0, 1'b1, "chg_a");
    Prescale = 6'd16;
    run_bits(8, 16, 39, 1'b1, 32'h0, 1'b1, "chg_b");
    enable_run(6'd16);
    run_bits(16, 1, 27, 1'b1, 32'h0, 1'b1, "chg_c");

    // Disable at edge 5 (= M+1 for P=8) of bit 1: no strobe, counters clear,
    // sampled_bit keeps the 0 voted in bit 0 even though bit 1 sampled high.
    enable_run(6'd8);
    run_bits(8, 1, 7, 1'b0, 32'h0, 1'b0, "dis_a");
    run_bits(8, 8, 14, 1'b1, 32'h0, 1'b1, "dis_b");
    sampler_en = 1'b0;
    tick();
    check("dis.strobe", 32'(Sample_Available), 32'd0);
    check("dis.edge",   32'(edge_cnt), 32'd0);
    check("dis.bit",    32'(bit_cnt), 32'd0);
    check("dis.sbit",   32'(sampled_bit), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dis.idle_strobe", 32'(Sample_Available), 32'd0);
      check("dis.idle_edge",   32'(edge_cnt), 32'd0);
    end
    enable_run(6'd8);
    run_bits(8, 1, 7, 1'b1, 32'h0, 1'b1, "reen");

    // Asynchronous reset at edge 4 of bit 3 with the enable still high.
    enable_run(6'd8);
    run_bits(8, 1, 29, 1'b0, 32'h0, 1'b0, "pre_rst");
    check("pre_rst.edge4", 32'(edge_cnt), 32'd4);
    check("pre_rst.bit3",  32'(bit_cnt), 32'd3);
    check("pre_rst.sbit0", 32'(sampled_bit), 32'd0);
    #1;
    RST = 1'b0;
    #1;
    check("arst.sbit",   32'(sampled_bit), 32'd1);
    check("arst.strobe", 32'(Sample_Available), 32'd0);
    check("arst.edge",   32'(edge_cnt), 32'd0);
    check("arst.bit",    32'(bit_cnt), 32'd0);
    #2;
    RST = 1'b1;
    run_bits(8, 1, 15, 1'b0, 32'h0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receiver. Counts oversampling edges and bit periods on the raw serial line, takes three majority-voted samples around the centre of each bit, and emits one registered bit per bit period with a single-cycle valid strobe. `sampled_bit` and `Sample_Available` drive the parity, start and stop checkers and the deserializer. `edge_cnt` and `bit_cnt` feed the RX control FSM.

## Interface
Parameters:
- `PRESCALE_W`, default 6: width of the `Prescale` input.
- `BIT_CNT_W`, default 4: width of `bit_cnt`.

Ports:
- `CLK`  input  1: oversampling clock.
- `RST`  input  1: asynchronous, active-low reset.
- `RX_IN`  input  1: serial line, already synchronised to `CLK`.
- `Prescale`  input  `PRESCALE_W`: oversampling ratio. Legal values are 8, 16 and 32.
- `sampler_en`  input  1: run enable from the RX FSM.
- `sampled_bit`  output  1: majority-voted value of the current bit.
- `Sample_Available`  output  1: one-cycle strobe marking `sampled_bit` as new.
- `edge_cnt`  output  `PRESCALE_W`: oversampling edge index within the current bit.
- `bit_cnt`  output  `BIT_CNT_W`: index of the current bit within the frame.

## Operation
- Prescale latch:
  - `Prescale` is captured into an internal register `P` on the cycle where `sampler_en` goes from 0 to 1.
  - `P` holds for the whole enabled run. Changes to `Prescale` while enabled have no effect.
  - A value other than 8, 16 or 32 is latched as 8.
- Edge counter, while enabled:
  - `edge_cnt` increments by 1 each cycle over the range 0 to P-1.
  - At P-1 it wraps to 0.
- Bit counter:
  - `bit_cnt` increments by 1 on every cycle where `edge_cnt` wraps.
  - It wraps from 2^`BIT_CNT_W`-1 to 0. The FSM disables the block before that happens.
- Sample points: the middle edges `M-1`, `M` and `M+1`, where `M` = P/2.
  - P=8: edges 3, 4, 5.
  - P=16: edges 7, 8, 9.
  - P=32: edges 15, 16, 17.
- Sampling and vote:
  - `RX_IN` is stored into s0 at edge `M-1` and into s1 at edge `M`.
  - At edge `M+1`, `sampled_bit` is set to the majority of s0, s1 and the current `RX_IN`, i.e. (s0&s1)|(s0&RX_IN)|(s1&RX_IN).
  - `Sample_Available` is set to 1 on that same clock edge.
  - `Sample_Available` returns to 0 on the next clock. It is high for exactly one cycle per bit.
- Disable (`sampler_en`=0), applied synchronously:
  - `edge_cnt`, `bit_cnt`, s0, s1 and `Sample_Available` are cleared to 0.
  - `sampled_bit` holds its last value.
  - Re-enabling restarts at `edge_cnt`=0, `bit_cnt`=0 and re-latches `Prescale`.
- Reset mid-operation: asynchronous `RST` low forces every register to its reset value immediately.
  - Counters, s0, s1 and `Sample_Available` go to 0.
  - `sampled_bit` goes to 1, the idle line level.
  - `P` goes to 8.
  - On release, the block stays idle until `sampler_en` is next seen high. A `sampler_en` already high at release counts as a 0→1 transition.

## Timing
- Reset values: `sampled_bit`=1, `Sample_Available`=0, `edge_cnt`=0, `bit_cnt`=0.
- Enable to counting:
  - On the first enabled clock, `Prescale` is latched and `edge_cnt` stays at 0.
  - `edge_cnt` reads 1 after the second enabled clock.
  - The first enabled cycle is edge 0.
- Sample latency: `sampled_bit` and `Sample_Available` update one clock after the cycle in which `edge_cnt`=`M+1`.
  - For P=8, the strobe is visible while `edge_cnt`=6.
  - One bit period is P cycles.
- Every output is registered. There is no combinational path from `RX_IN` to any output.
- Simultaneous events:
  - `sampler_en` falling in the same cycle as edge `M+1`: disable wins and no strobe is issued.
  - `edge_cnt` wrap and `bit_cnt` increment happen on the same clock edge.

## Test plan
- Reset, then P=8, `sampler_en`=1, `RX_IN` constant 0 for 10 bits → 10 strobes spaced exactly 8 cycles apart, each with `sampled_bit`=0. `bit_cnt` reaches 9 at the 10th strobe. `edge_cnt` reads 6 on every strobe cycle.
- P=16, `RX_IN`=1 except a one-cycle 0 glitch at edge 8 → `sampled_bit`=1. Glitch on two of edges 7, 8, 9 → `sampled_bit`=0.
- P=32 then P=13 (illegal) → strobes every 32 cycles for the first run. For the second run the value latches as 8 and strobes come every 8 cycles.
- `Prescale` changed from 8 to 16 mid-run → strobe spacing stays 8. It becomes 16 only after a disable/enable.
- Deassert `sampler_en` at `edge_cnt`=5 with P=8 → no strobe that bit, counters read 0 next cycle, `sampled_bit` holds. Re-enable → first strobe 7 cycles later.
- Assert `RST` while `edge_cnt`=4 and `bit_cnt`=3 → outputs go immediately to 1/0/0/0 without waiting for a clock edge. After release with `sampler_en` high, counting restarts from 0.
